// File: rtl/cd_sector_tx_if.sv
// Payload stream in and CD_D/CD_CK data port out of the sector transmitter.
interface cd_sector_tx_if;
  logic [15:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] CD_D;
  logic        CD_CK;
  logic        CD_FULL;

  // master is the surrounding system (feeder + CD-block FIFO), slave is the transmitter
  modport master (output IN_DATA, IN_VALID, CD_FULL, input IN_READY, CD_D, CD_CK);
  modport slave  (input IN_DATA, IN_VALID, CD_FULL, output IN_READY, CD_D, CD_CK);
endinterface

// File: rtl/cd_sector_tx.sv
// Paced raw-sector transmitter: 12-byte sync + SECT_WORDS payload words per sector,
// one registered CD_CK strobe per word period, stalled by CD_FULL or an empty FIFO.
module cd_sector_tx #(
  parameter int DIV        = 500,
  parameter int SECT_WORDS = 1170
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PLAY,
  input  logic          SPEED,
  input  logic          FLUSH,
  cd_sector_tx_if.slave io,
  output logic          BUSY,
  output logic          SECT_DONE,
  output logic          UNDERRUN,
  output logic [15:0]   SECTOR_CNT
);
  localparam int IW = $clog2(SECT_WORDS);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] SYNC_LAST = IW'(5);
  localparam logic [IW-1:0] DATA_LAST = IW'(SECT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0][15:0] mem_q, mem_d;
  logic [1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [2:0]      lvl_q, lvl_d;
  logic [15:0]     cd_d_q, cd_d_d;
  logic            cd_ck_q, cd_ck_d;
  logic            done_q, done_d;
  logic            under_q, under_d;
  logic [15:0]     scnt_q, scnt_d;

  logic [15:0] period_m1, sync_word;
  logic        due, strobe, push, pop, flush_ok;

  assign period_m1 = SPEED ? 16'(DIV / 2 - 1) : 16'(DIV - 1);

  // Low byte goes out first on the disc, so the 00 FF..FF 00 pattern packs as below
  always_comb begin
    unique case (idx_q[2:0])
      3'd0:    sync_word = 16'hFF00;
      3'd5:    sync_word = 16'h00FF;
      default: sync_word = 16'hFFFF;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mem_d    = mem_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    cd_d_d   = cd_d_q;
    cd_ck_d  = 1'b0;
    done_d   = 1'b0;
    under_d  = under_q;
    scnt_d   = scnt_q + 16'(done_q);
    due      = (cnt_q == 16'd0);
    strobe   = 1'b0;
    pop      = 1'b0;
    flush_ok = FLUSH && (state_q == IDLE);

    unique case (state_q)
      IDLE: if (PLAY) begin
        state_d = SYNC;
        idx_d   = '0;
        cnt_d   = period_m1;
      end
      SYNC: begin
        strobe = due && !io.CD_FULL;
        if (strobe) begin
          cd_d_d = sync_word;
          if (idx_q == SYNC_LAST) begin
            state_d = DATA;
            idx_d   = '0;
          end else idx_d = idx_q + IDX_ONE;
        end
      end
      DATA: begin
        strobe = due && !io.CD_FULL && (lvl_q != 3'd0);
        if (due && lvl_q == 3'd0) under_d = 1'b1;
        if (strobe) begin
          pop    = 1'b1;
          cd_d_d = mem_q[rp_q];
          if (idx_q == DATA_LAST) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = PLAY ? SYNC : IDLE;
          end else idx_d = idx_q + IDX_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reload on the strobe itself so back-to-back words are exactly one period apart
    if (strobe) begin
      cd_ck_d = 1'b1;
      cnt_d   = period_m1;
    end else if (state_q != IDLE && !due) begin
      cnt_d = cnt_q - 16'd1;
    end

    push = io.IN_VALID && io.IN_READY && !flush_ok;
    if (push) begin
      mem_d[wp_q] = io.IN_DATA;
      wp_d        = wp_q + 2'd1;
    end
    if (pop) rp_d = rp_q + 2'd1;
    lvl_d = lvl_q + 3'(push) - 3'(pop);

    if (flush_ok) begin
      wp_d    = '0;
      rp_d    = '0;
      lvl_d   = '0;
      under_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mem_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      cd_d_q  <= '0;
      cd_ck_q <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      cd_d_q  <= cd_d_d;
      cd_ck_q <= cd_ck_d;
      done_q  <= done_d;
      under_q <= under_d;
      scnt_q  <= scnt_d;
    end
  end

  assign io.CD_D     = cd_d_q;
  assign io.CD_CK    = cd_ck_q;
  assign io.IN_READY = (lvl_q != 3'd4);
  assign BUSY        = (state_q != IDLE);
  assign SECT_DONE   = done_q;
  assign UNDERRUN    = under_q;
  assign SECTOR_CNT  = scnt_q;
endmodule

// File: tb/tb_cd_sector_tx.sv
// Directed bench for cd_sector_tx at DIV=8: pacing, sync/payload order, stalls, flush, reset.
module tb_cd_sector_tx;
  localparam int DIV  = 8;
  localparam int SW   = 1170;
  localparam int NS   = SW + 6;
  localparam int NONE = -1000;

  logic        CLK = 1'b0;
  logic        RST_N, PLAY, SPEED, FLUSH;
  logic        BUSY, SECT_DONE, UNDERRUN;
  logic [15:0] SECTOR_CNT;

  cd_sector_tx_if ifc();

  cd_sector_tx #(.DIV(DIV), .SECT_WORDS(SW)) dut (
    .CLK(CLK), .RST_N(RST_N), .PLAY(PLAY), .SPEED(SPEED), .FLUSH(FLUSH),
    .io(ifc), .BUSY(BUSY), .SECT_DONE(SECT_DONE), .UNDERRUN(UNDERRUN),
    .SECTOR_CNT(SECTOR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, spur = 0, last_ck = 0;
  int feed_val = 0, feed_stop = -1;
  bit feed_en = 1'b0, took = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (SECT_DONE === 1'b1 && ifc.CD_CK !== 1'b1) spur <= spur + 1;

  // Feeder: offers an incrementing word each cycle, holding back at feed_stop
  initial begin
    ifc.IN_VALID = 1'b0;
    ifc.IN_DATA  = '0;
    forever begin
      @(negedge CLK);
      if (took) feed_val++;
      ifc.IN_VALID = feed_en && (feed_val != feed_stop);
      ifc.IN_DATA  = 16'(feed_val);
      took = ifc.IN_VALID && ifc.IN_READY;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sync_w(input int k);
    if (k == 0) return 16'hFF00;
    if (k == 5) return 16'h00FF;
    return 16'hFFFF;
  endfunction

  task automatic wait_ck(output logic [15:0] w, output int g, output bit ok);
    ok = 1'b0; w = '0; g = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (ifc.CD_CK === 1'b1) begin
        ok = 1'b1; w = ifc.CD_D; g = cyc - last_ck; last_ck = cyc;
      end
    end
  endtask

  // Receives n strobes of a sector starting at its first sync word; hooks fire after
  // the given payload index (or strobe index for flush_at).
  task automatic rx_sector(input string tag, input int base, input int gap, input int n,
                           input int drop_at, input int full_at, input int starve_at,
                           input int flush_at);
    logic [15:0] w, ew;
    int g, want, bad_v, bad_g, bad_d, nck;
    bit ok;
    bad_v = 0; bad_g = 0; bad_d = 0; want = gap;
    for (int k = 0; k < n; k++) begin
      wait_ck(w, g, ok);
      if (!ok) begin chk({tag, "_timeout"}, k, n); break; end
      ew = (k < 6) ? sync_w(k) : 16'(base + k - 6);
      if (w !== ew) bad_v++;
      if (want >= 0 && g != want) bad_g++;
      if (SECT_DONE !== (k == NS - 1)) bad_d++;
      want = gap;
      if (k - 6 == drop_at) PLAY = 1'b0;
      if (k == flush_at) begin FLUSH = 1'b1; @(negedge CLK); FLUSH = 1'b0; end
      if (k - 6 == full_at) begin
        CD_FULL_hold(nck);
        chk({tag, "_full_no_ck"}, nck, 0);
        chk({tag, "_full_no_underrun"}, UNDERRUN, 0);
        want = 21;
      end
      if (k - 6 == starve_at) begin
        nck = 0;
        repeat (50) begin @(negedge CLK); if (ifc.CD_CK === 1'b1) nck++; end
        feed_stop = -1;
        chk({tag, "_starve_no_ck"}, nck, 0);
        chk({tag, "_underrun_set"}, UNDERRUN, 1);
        want = -1;
      end
    end
    chk({tag, "_values_bad"}, bad_v, 0);
    chk({tag, "_gaps_bad"}, bad_g, 0);
    chk({tag, "_sect_done_bad"}, bad_d, 0);
  endtask

  task automatic CD_FULL_hold(output int nck);
    nck = 0;
    ifc.CD_FULL = 1'b1;
    repeat (20) begin @(negedge CLK); if (ifc.CD_CK === 1'b1) nck++; end
    ifc.CD_FULL = 1'b0;
  endtask

  task automatic restart();
    feed_en = 1'b0; PLAY = 1'b0; FLUSH = 1'b0; ifc.CD_FULL = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    feed_val = 0; feed_stop = -1; feed_en = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  initial begin
    logic [15:0] w;
    int g, nck;
    bit ok;
    RST_N = 1'b0; PLAY = 1'b0; SPEED = 1'b0; FLUSH = 1'b0; ifc.CD_FULL = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_cd_d", ifc.CD_D, 0);
    chk("rst_cd_ck", ifc.CD_CK, 0);
    chk("rst_in_ready", ifc.IN_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_sect_done", SECT_DONE, 0);
    chk("rst_underrun", UNDERRUN, 0);
    chk("rst_sector_cnt", SECTOR_CNT, 0);

    // 1x, one sector, PLAY dropped at payload 100
    restart();
    SPEED = 1'b0; PLAY = 1'b1; last_ck = cyc + 1;
    rx_sector("s1x", 0, DIV, NS, 100, NONE, NONE, NONE);
    chk("s1x_busy_low", BUSY, 0);
    chk("s1x_cnt_not_yet", SECTOR_CNT, 0);
    @(negedge CLK);
    chk("s1x_sector_cnt", SECTOR_CNT, 1);
    nck = 0;
    repeat (3 * DIV) begin @(negedge CLK); if (ifc.CD_CK === 1'b1) nck++; end
    chk("s1x_no_new_sync", nck, 0);

    // 2x, two back-to-back sectors
    restart();
    SPEED = 1'b1; PLAY = 1'b1; last_ck = cyc + 1;
    rx_sector("s2x_a", 0, DIV / 2, NS, NONE, NONE, NONE, NONE);
    rx_sector("s2x_b", SW, DIV / 2, NS, 100, NONE, NONE, NONE);
    chk("s2x_busy_low", BUSY, 0);
    @(negedge CLK);
    chk("s2x_sector_cnt", SECTOR_CNT, 2);

    // CD_FULL stall + ignored FLUSH, then underrun after payload 10 of the next sector
    restart();
    SPEED = 1'b0; feed_stop = SW + 11; PLAY = 1'b1; last_ck = cyc + 1;
    rx_sector("full", 0, DIV, NS, NONE, 20, NONE, 2);
    rx_sector("starve", SW, DIV, NS, 100, NONE, 10, NONE);
    chk("starve_busy_low", BUSY, 0);
    @(negedge CLK);
    feed_en = 1'b0;
    chk("starve_sector_cnt", SECTOR_CNT, 2);
    chk("starve_underrun_sticky", UNDERRUN, 1);
    @(negedge CLK);
    chk("fifo_full_before_flush", ifc.IN_READY, 0);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    chk("flush_clears_underrun", UNDERRUN, 0);
    chk("flush_empties_fifo", ifc.IN_READY, 1);

    // Asynchronous reset at payload 500, restart from sync
    feed_val = 0; feed_en = 1'b1;
    repeat (6) @(negedge CLK);
    PLAY = 1'b1; last_ck = cyc + 1;
    rx_sector("prerst", 0, DIV, 507, NONE, NONE, NONE, NONE);
    feed_en = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("arst_cd_ck", ifc.CD_CK, 0);
    chk("arst_cd_d", ifc.CD_D, 0);
    chk("arst_sector_cnt", SECTOR_CNT, 0);
    chk("arst_in_ready", ifc.IN_READY, 1);
    chk("arst_busy", BUSY, 0);
    repeat (2) @(negedge CLK);
    feed_val = 0; feed_en = 1'b1;
    RST_N = 1'b1;
    last_ck = cyc + 1;
    wait_ck(w, g, ok);
    chk("post_rst_strobe_seen", ok, 1);
    chk("post_rst_first_word", w, 16'hFF00);
    chk("post_rst_latency", g, DIV);

    chk("sect_done_spurious", spur, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cd_sector_tx.md
# cd_sector_tx

Paced raw-sector transmitter for the CD data port. Accepts raw sector payload words from the drive-emulation side over a valid/ready stream. Prefixes each sector with the 12-byte sync pattern and emits 16-bit words on CD_D with a one-cycle CD_CK write strobe. Output runs at 1x or 2x CD rate and honours back-pressure from the CD-block input FIFO. It is the producer end of the CD_D/CD_CK interface consumed by the CD host-interface block.

## Interface
- DIV, 500, CLK cycles per word at 1x speed; 44.1 MHz / 88200 words/s. Must be even and ≥4.
- SECT_WORDS, 1170, payload words per sector after sync (2352 − 12 bytes) / 2.
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- PLAY  in  1  level; 1 = keep transmitting sectors back-to-back.
- SPEED  in  1  0 = 1x (period DIV), 1 = 2x (period DIV/2); sampled at the start of each word period.
- FLUSH  in  1  one-cycle pulse; empties the input FIFO; honoured only in IDLE.
- IN_DATA  in  16  payload word; header, subheader, user data and EDC/ECC in disc order.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  input FIFO not full.
- CD_FULL  in  1  receiver FIFO full; no strobe may be issued while high.
- CD_D  out  16  data word; valid in the CD_CK cycle.
- CD_CK  out  1  one-CLK write strobe.
- BUSY  out  1  state ≠ IDLE.
- SECT_DONE  out  1  one-cycle pulse when the last payload word is strobed.
- UNDERRUN  out  1  sticky; set when a word is due but the FIFO is empty; cleared by FLUSH or reset.
- SECTOR_CNT  out  16  completed sectors, wraps 0xFFFF→0.

## Operation
- Input FIFO: 4 entries × 16 bit. A write occurs when IN_VALID & IN_READY. A simultaneous read and write with the FIFO full is not permitted, because IN_READY=0 when full.
- States: IDLE, SYNC, DATA.
  - IDLE→SYNC: when PLAY=1. Word index is cleared and the pacing counter is loaded.
  - SYNC: emits 6 words: 0xFF00, 0xFFFF, 0xFFFF, 0xFFFF, 0xFFFF, 0x00FF. Low byte is the earlier disc byte. After the 6th word → DATA.
  - DATA: emits SECT_WORDS words popped from the FIFO. After the last word, SECT_DONE=1 and SECTOR_CNT increments. Next state is SYNC if PLAY=1, else IDLE.
- Dropping PLAY mid-sector does not truncate the sector. The current sector always completes.
- Pacing counter (16 bit):
  - Counts down from period−1 to 0, then holds at 0 with the word "due".
  - A due word is strobed in the first cycle where CD_FULL=0 and, in DATA only, the FIFO is non-empty.
  - The counter reloads in the strobe cycle.
  - Consecutive strobes are therefore ≥ period cycles apart, never closer.
- Underrun: in DATA, due with the FIFO empty sets UNDERRUN. Transmission stalls; no word is skipped or invented. The word is sent when data arrives.
- CD_FULL stalls in the same way but does not set UNDERRUN. SYNC words never depend on the FIFO.
- FLUSH outside IDLE is ignored.

## Timing
- Reset values: CD_D=0, CD_CK=0, IN_READY=1, BUSY=0, SECT_DONE=0, UNDERRUN=0, SECTOR_CNT=0, state IDLE, FIFO empty.
- First SYNC strobe: period cycles after the IDLE→SYNC transition cycle.
- CD_D and CD_CK are registered. CD_CK is high for exactly one cycle per word; CD_D holds its value until the next strobe.
- CD_FULL is sampled combinationally in the cycle that decides the strobe. A registered strobe therefore never follows a CD_FULL=1 cycle.
- FIFO pop coincides with the DATA strobe register load. IN_READY rises the cycle after a pop from full.
- SECT_DONE is asserted in the same cycle as the last payload CD_CK. SECTOR_CNT updates on the following edge.
- Reset mid-sector aborts immediately: all outputs return to reset values and FIFO contents are lost.

## Test plan
- DIV=8, SPEED=0, PLAY=1 for one sector, FIFO fed continuously with an incrementing pattern from 0x0000 → 1176 strobes spaced exactly 8 cycles. First six are FF00, FFFF×4, 00FF, then 0x0000..0x0491. One SECT_DONE; SECTOR_CNT=1; then IDLE once PLAY=0.
- SPEED=1, DIV=8, two back-to-back sectors with PLAY held → strobes 4 cycles apart. No extra gap between the last payload word and the next 0xFF00. SECTOR_CNT=2.
- CD_FULL held high for 20 cycles during DATA → no CD_CK while high. The pending word is strobed in the first cycle after release. UNDERRUN stays 0 and no data is lost or duplicated.
- IN_VALID withheld after payload word 10 for 50 cycles → UNDERRUN=1, stall, then word 11 is strobed. The remaining sequence is intact; FLUSH in IDLE clears UNDERRUN.
- PLAY dropped at payload word 100 → the sector completes all 1170 words, SECT_DONE pulses, BUSY falls, and no new sync words are sent.
- RST_N asserted at payload word 500 → CD_CK=0, CD_D=0, SECTOR_CNT=0, IN_READY=1 asynchronously. After release with PLAY=1, transmission restarts with 0xFF00.
